// File: rtl/alu_seq_if.sv
// Request/result bundle between the issuing datapath and the sequential ALU.
// The master drives operands and Start; the slave returns result, flags and handshake.
interface alu_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         zero;
  logic         carry;
  logic         neg;
  logic         busy;
  logic         done;

  modport master (
    output start, op, a, b, carry_in,
    input  out, out_hi, zero, carry, neg, busy, done
  );

  modport slave (
    input  start, op, a, b, carry_in,
    output out, out_hi, zero, carry, neg, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic/shift ops plus a W-step
// shift-add unsigned multiplier, with Start/Busy/Done handshake and flags.
module alu_seq #(
  parameter int W = 8,
  parameter int S = $clog2(W)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LSL = 4'd3;
  localparam logic [3:0] OP_LSR = 4'd4;
  localparam logic [3:0] OP_ASR = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MULT = 1'b1;

  localparam logic [S:0] CNT_LAST = (S+1)'(W - 1);
  localparam logic [S:0] CNT_ONE  = (S+1)'(1);

  logic [0:0]   state_q, state_d;
  logic [S:0]   cnt_q, cnt_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] acc_hi_q, acc_hi_d;
  logic [W-1:0] acc_lo_q, acc_lo_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] out_hi_q, out_hi_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         neg_q, neg_d;
  logic         done_q, done_d;

  logic [S-1:0] sh_amt;
  logic [W:0]   sum_w;
  logic [W:0]   lsl_w;
  logic [W:0]   rsh_w;
  logic [W-1:0] alu_res;
  logic         alu_c;

  logic [W:0]   step_sum;
  logic [W-1:0] step_hi;
  logic [W-1:0] step_lo;

  assign sh_amt = bus.b[S-1:0];

  // Shifts run on a W+1 wide word so the last bit shifted out lands in a
  // fixed position; a zero shift naturally leaves that position clear.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum_w   = '0;
    lsl_w   = '0;
    rsh_w   = '0;
    case (bus.op)
      OP_ADD: begin
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
      end
      OP_ADC: begin
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.carry_in};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
      end
      OP_SUB: begin
        sum_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, 1'b1};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
      end
      OP_LSL: begin
        lsl_w   = {1'b0, bus.a} << sh_amt;
        alu_res = lsl_w[W-1:0];
        alu_c   = lsl_w[W];
      end
      OP_LSR: begin
        rsh_w   = {bus.a, 1'b0} >> sh_amt;
        alu_res = rsh_w[W:1];
        alu_c   = rsh_w[0];
      end
      OP_ASR: begin
        rsh_w   = $unsigned($signed({bus.a, 1'b0}) >>> sh_amt);
        alu_res = rsh_w[W:1];
        alu_c   = rsh_w[0];
      end
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // One shift-add step: the multiplier sits in acc_lo and is consumed LSB first
  // while partial product bits shift down into it from acc_hi.
  always_comb begin
    step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    step_hi  = step_sum[W:1];
    step_lo  = {step_sum[0], acc_lo_q[W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mcand_d  = bus.a;
            acc_lo_d = bus.b;
            acc_hi_d = '0;
            cnt_d    = '0;
            state_d  = ST_MULT;
          end else begin
            out_d    = alu_res;
            out_hi_d = '0;
            zero_d   = (alu_res == '0);
            carry_d  = alu_c;
            neg_d    = alu_res[W-1];
            done_d   = 1'b1;
          end
        end
      end
      ST_MULT: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          out_d    = step_lo;
          out_hi_d = step_hi;
          zero_d   = ({step_hi, step_lo} == '0);
          carry_d  = 1'b0;
          neg_d    = step_hi[W-1];
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.out_hi = out_hi_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
  assign bus.neg    = neg_q;
  assign bus.busy   = (state_q == ST_MULT);
  assign bus.done   = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with a Start/Busy/Done handshake, status flags and an iterative unsigned multiplier. It sits between the register file and the writeback mux. It replaces the purely combinational 8-bit ALU in datapaths that need wider words, carry-chained arithmetic, variable shifts or multiply. Single-cycle operations complete in one clock. MUL completes in W+1 clocks.

## Interface
- W, default 8: data width in bits, legal for W ≥ 4 and a power of two.
- S, default $clog2(W): shift-amount width, derived from W; do not override.
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- OP  in  4  opcode, sampled with Start.
- InputA  in  W  operand A, sampled with Start.
- InputB  in  W  operand B, sampled with Start.
- CarryIn  in  1  carry input for ADC, sampled with Start.
- Out  out  W  result; MUL low word.
- OutHi  out  W  MUL high word; 0 for every other op.
- Zero  out  1  result equals zero.
- Carry  out  1  carry, no-borrow or last bit shifted out.
- Neg  out  1  MSB of result.
- Busy  out  1  multiply in progress.
- Done  out  1  one-cycle pulse: new result and flags valid.

## Operation
- Opcodes:
  - 0 ADD: A+B. Carry = bit W of the sum.
  - 1 ADC: A+B+CarryIn. Carry = bit W of the sum.
  - 2 SUB: A−B mod 2^W. Carry = 1 iff A ≥ B (unsigned no-borrow).
  - 3 LSL: A << B[S-1:0].
  - 4 LSR: A >> B[S-1:0].
  - 5 ASR: arithmetic right shift of A by B[S-1:0].
  - 6 XOR, 7 AND, 8 OR: bitwise.
  - 9 MUL: unsigned A×B, 2W-bit product = {OutHi, Out}.
  - 10–15 reserved: Out=0, OutHi=0, Zero=1, Carry=0, Neg=0.
- Shift Carry = last bit shifted out. Shift amount 0 gives Carry=0 and Out=A. Bits of InputB above S-1 are ignored.
- Carry is 0 for XOR, AND, OR and MUL.
- Zero:
  - non-MUL ops: (Out == 0).
  - MUL: ({OutHi,Out} == 0).
- Neg:
  - non-MUL ops: Out[W-1].
  - MUL: OutHi[W-1].
- States:
  - IDLE: Start=1 with a non-MUL op → register result and flags, pulse Done, stay in IDLE.
  - IDLE: Start=1 with OP=9 → latch multiplicand, multiplier and a step counter of width S+1; go to MULT.
  - MULT: one shift-add step per cycle, W steps total. On the final step write {OutHi,Out} and flags, pulse Done, return to IDLE.
- Out, OutHi and flags hold their last values until the next completion. They do not change while Busy=1.
- Start while Busy=1 is ignored, with no queuing.

## Timing
- Reset values: Out=0, OutHi=0, Zero=0, Carry=0, Neg=0, Busy=0, Done=0. FSM goes to IDLE and the counter clears.
- Non-MUL op, Start sampled at edge k:
  - result and flags visible after edge k.
  - Done=1 for exactly the cycle between edges k and k+1.
  - Latency is 1; back-to-back issue every cycle is legal.
- MUL, Start sampled at edge k:
  - Busy=1 for the W cycles between edges k and k+W.
  - result valid after edge k+W; Done=1 for the cycle between edges k+W and k+W+1.
  - Busy=0 in the Done cycle, so a new Start in that cycle is accepted at edge k+W+1.
- Done is never asserted for two consecutive cycles unless two operations complete at consecutive edges.
- Reset mid-MULT: the operation is aborted, Done is never pulsed for it, and all outputs return to reset values after that edge.
- Reset and Start at the same edge: Reset wins and Start is dropped.

## Test plan
- Reset, then ADD with A=0xF0, B=0x20 (W=8) → after 1 edge: Out=0x10, Carry=1, Zero=0, Neg=0, one-cycle Done.
- Two SUBs back to back:
  - 0x05−0x05 → Out=0x00, Zero=1, Carry=1.
  - next cycle 0x03−0x05 → Out=0xFE, Carry=0, Neg=1.
  - Done high for 2 consecutive cycles.
- Shifts:
  - LSR A=0x81, B=1 → Out=0x40, Carry=1.
  - ASR A=0x80, B=0x03 → Out=0xF0, Carry=0.
  - LSL A=0x5A, B=0x00 → Out=0x5A, Carry=0.
- MUL 0xFF×0xFF:
  - → OutHi=0xFE, Out=0x01.
  - Busy high exactly 8 cycles; Done exactly 8 edges after the Start edge.
  - an ADD Start driven mid-run is ignored and Out is unchanged until Done.
  - ADC 0xFF+0x00 with CarryIn=1 issued in the Done cycle → Out=0x00, Zero=1, Carry=1.
- Reset asserted in the 4th Busy cycle of MUL 0x12×0x34 → outputs all 0, no Done pulse. Then ADD 0x01+0x01 → Out=0x02.
- Reserved OP=0xC with A=0xFF → Out=0, OutHi=0, Zero=1, Carry=0, one-cycle Done. Repeat at W=16: MUL 0xFFFF×0x0002 → {OutHi,Out}=0x0001_FFFE, Busy 16 cycles.
